// File: rtl/artyz7_led_driver.sv
// Shows one LED pattern command at a time: PWM-dims the enabled LEDs for a number
// of PWM periods, then blanks the LEDs and accepts the next command.
module artyz7_led_driver #(
  parameter int num_leds      = 4,
  parameter int prescaler_div = 125,
  parameter int pwm_width     = 8
) (
  input  logic                 clk_ext,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:num_leds-1]  in_pattern,
  input  logic [pwm_width-1:0] in_duty,
  input  logic [15:0]          in_hold,
  output logic [0:num_leds-1]  led,
  output logic                 busy,
  output logic                 done
);

  localparam int presc_w = (prescaler_div > 1) ? $clog2(prescaler_div) : 1;
  localparam logic [presc_w-1:0]   presc_max = presc_w'(prescaler_div - 1);
  localparam logic [pwm_width-1:0] step_max  = '1;

  typedef enum logic {
    IDLE,
    SHOW
  } state_e;

  state_e                 state_q;
  logic [presc_w-1:0]     presc_q;
  logic [pwm_width-1:0]   step_q;
  logic [15:0]            remain_q;
  logic [0:num_leds-1]    pattern_q;
  logic [pwm_width-1:0]   duty_q;
  logic [0:num_leds-1]    led_q;
  logic [0:num_leds-1]    led_d;
  logic                   in_ready_q;
  logic                   busy_q;

  logic presc_wrap;
  logic period_end;
  logic last_period;

  assign presc_wrap  = (presc_q == presc_max);
  assign period_end  = presc_wrap && (step_q == step_max);
  assign last_period = (remain_q == 16'd1);

  // Decoded from registers only, so it is high exactly on the final SHOW cycle.
  assign done = (state_q == SHOW) && period_end && last_period;

  always_comb begin
    // NOTE: every bit gets a default first so no latch is inferred.
    led_d = '0;
    for (int i = 0; i < num_leds; i++) begin
      led_d[i] = (state_q == SHOW) && pattern_q[i] && (step_q < duty_q);
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_ext) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      step_q     <= '0;
      remain_q   <= '0;
      pattern_q  <= '0;
      duty_q     <= '0;
      led_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      led_q <= led_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            pattern_q  <= in_pattern;
            duty_q     <= in_duty;
            remain_q   <= (in_hold == 16'd0) ? 16'd1 : in_hold;
            presc_q    <= '0;
            step_q     <= '0;
            state_q    <= SHOW;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHOW: begin
          presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
          if (presc_wrap) begin
            step_q <= step_q + 1'b1;
          end
          if (period_end) begin
            if (last_period) begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              remain_q <= remain_q - 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led      = led_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_artyz7_led_driver.sv
// Directed bench for artyz7_led_driver: two instances, prescaler_div=2 and =1,
// both with pwm_width=3, sharing command fields but with separate valids.
module tb_artyz7_led_driver;

  logic       clk_ext;
  logic       rst_n;
  logic       in_valid_a, in_valid_b;
  logic [0:3] in_pattern;
  logic [2:0] in_duty;
  logic [15:0] in_hold;

  logic       in_ready_a, busy_a, done_a;
  logic [0:3] led_a;
  logic       in_ready_b, busy_b, done_b;
  logic [0:3] led_b;

  logic       sel;
  logic       cur_ready, cur_busy, cur_done;
  logic [0:3] cur_led;

  int checks = 0;
  int errors = 0;

  logic       busy_h  [0:127];
  logic       done_h  [0:127];
  logic       ready_h [0:127];
  logic [0:3] led_h   [0:127];

  artyz7_led_driver #(.num_leds(4), .prescaler_div(2), .pwm_width(3)) u_dut_a (
    .clk_ext(clk_ext), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pattern(in_pattern), .in_duty(in_duty), .in_hold(in_hold),
    .led(led_a), .busy(busy_a), .done(done_a)
  );

  artyz7_led_driver #(.num_leds(4), .prescaler_div(1), .pwm_width(3)) u_dut_b (
    .clk_ext(clk_ext), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pattern(in_pattern), .in_duty(in_duty), .in_hold(in_hold),
    .led(led_b), .busy(busy_b), .done(done_b)
  );

  assign cur_ready = sel ? in_ready_b : in_ready_a;
  assign cur_busy  = sel ? busy_b     : busy_a;
  assign cur_done  = sel ? done_b     : done_a;
  assign cur_led   = sel ? led_b      : led_a;

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples the selected DUT into history slots [start, start+n), one per cycle.
  task automatic record(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      busy_h[i]  = cur_busy;
      done_h[i]  = cur_done;
      ready_h[i] = cur_ready;
      led_h[i]   = cur_led;
      step();
    end
  endtask

  function automatic int count_busy(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(busy_h[i]);
    return c;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(done_h[i]);
    return c;
  endfunction

  function automatic int count_led(input int bitn, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(led_h[i][bitn]);
    return c;
  endfunction

  // Sends one command and checks its duration, done position and per-LED on-counts.
  // History index 0 is the first SHOW cycle; the LED output lags state by one cycle.
  task automatic run_cmd(input string tag, input logic use_b, input logic [0:3] pat,
                         input logic [2:0] duty, input logic [15:0] hold, input int len,
                         input int e0, input int e1, input int e2, input int e3);
    sel = use_b;
    #1;
    check({tag, ".ready_before"}, int'(cur_ready), 1);
    in_pattern = pat;
    in_duty    = duty;
    in_hold    = hold;
    if (use_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    record(0, len + 6);
    check({tag, ".busy_cycles"}, count_busy(0, len + 5), len);
    check({tag, ".done_count"}, count_done(0, len + 5), 1);
    check({tag, ".done_last"}, int'(done_h[len - 1]), 1);
    check({tag, ".idle_after"}, int'(ready_h[len]), 1);
    check({tag, ".led_first_out"}, int'(led_h[1]), (duty != 3'd0) ? int'(pat) : 0);
    check({tag, ".led0_on"}, count_led(0, 1, len), e0);
    check({tag, ".led1_on"}, count_led(1, 1, len), e1);
    check({tag, ".led2_on"}, count_led(2, 1, len), e2);
    check({tag, ".led3_on"}, count_led(3, 1, len), e3);
    check({tag, ".led_blank"}, int'(led_h[len + 1]), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_pattern = '0;
    in_duty    = '0;
    in_hold    = '0;
    sel        = 1'b0;

    repeat (3) step();
    rst_n = 1'b1;
    check("reset.in_ready", int'(in_ready_a), 1);
    check("reset.busy", int'(busy_a), 0);
    check("reset.done", int'(done_a), 0);
    check("reset.led", int'(led_a), 0);
    check("reset.b_in_ready", int'(in_ready_b), 1);
    step();

    // 16-cycle period: duty 3 lights 3 steps x 2 cycles = 6 cycles per period.
    run_cmd("single", 1'b0, 4'b1010, 3'd3, 16'd2, 32, 12, 0, 12, 0);
    run_cmd("duty0",  1'b0, 4'b1111, 3'd0, 16'd1, 16, 0, 0, 0, 0);
    run_cmd("duty7",  1'b0, 4'b1111, 3'd7, 16'd1, 16, 14, 14, 14, 14);
    run_cmd("hold0",  1'b0, 4'b0100, 3'd4, 16'd0, 16, 0, 8, 0, 0);
    run_cmd("hold1",  1'b0, 4'b0100, 3'd4, 16'd1, 16, 0, 8, 0, 0);

    // Back-to-back: valid stays high; second command is presented as soon as
    // the first is taken and held stable until accepted.
    sel = 1'b0;
    in_pattern = 4'b1100;
    in_duty    = 3'd2;
    in_hold    = 16'd1;
    in_valid_a = 1'b1;
    step();
    in_pattern = 4'b0011;
    in_duty    = 3'd5;
    in_hold    = 16'd1;
    record(0, 17);
    in_valid_a = 1'b0;
    record(17, 20);
    check("b2b.first_done", int'(done_h[15]), 1);
    check("b2b.gap_ready", int'(ready_h[16]), 1);
    check("b2b.gap_busy", int'(busy_h[16]), 0);
    check("b2b.second_busy", int'(busy_h[17]), 1);
    check("b2b.second_done", int'(done_h[32]), 1);
    check("b2b.busy_cycles", count_busy(0, 36), 32);
    check("b2b.done_count", count_done(0, 36), 2);
    check("b2b.end_idle", int'(busy_h[33]), 0);
    check("b2b.led0_on", count_led(0, 1, 36), 4);
    check("b2b.led1_on", count_led(1, 1, 36), 4);
    check("b2b.led2_on", count_led(2, 1, 36), 10);
    check("b2b.led3_on", count_led(3, 1, 36), 10);

    // Reset pulse on SHOW cycle 10 of a hold=3 command.
    sel = 1'b0;
    in_pattern = 4'b1111;
    in_duty    = 3'd7;
    in_hold    = 16'd3;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    record(0, 9);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst.busy", int'(busy_a), 0);
    check("midrst.in_ready", int'(in_ready_a), 1);
    check("midrst.led", int'(led_a), 0);
    check("midrst.done", int'(done_a), 0);
    check("midrst.pre_busy", count_busy(0, 8), 9);
    record(9, 60);
    check("midrst.no_done", count_done(0, 68), 0);
    check("midrst.stays_idle", count_busy(9, 68), 0);
    run_cmd("after_rst", 1'b0, 4'b1010, 3'd3, 16'd1, 16, 6, 0, 6, 0);

    // prescaler_div=1: 8-cycle period, duty 3 lights 3 cycles per period.
    run_cmd("presc1", 1'b1, 4'b1010, 3'd3, 16'd2, 16, 6, 0, 6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
